// File: rtl/line_sensor_filter_if.sv
// Frame-in / filtered-result-out bundle between the ADC controller side and the
// line-sensor filter.
interface line_sensor_filter_if #(
    parameter int DATA_W = 12
);
    logic              frame_valid;
    logic [DATA_W-1:0] d_out_ch5;
    logic [DATA_W-1:0] d_out_ch6;
    logic [DATA_W-1:0] d_out_ch7;
    logic [DATA_W-1:0] avg_ch5;
    logic [DATA_W-1:0] avg_ch6;
    logic [DATA_W-1:0] avg_ch7;
    logic              avg_valid;
    logic              warm;
    logic [2:0]        black;
    logic              node_pulse;
    logic [7:0]        node_count;

    modport master (
        output frame_valid, d_out_ch5, d_out_ch6, d_out_ch7,
        input  avg_ch5, avg_ch6, avg_ch7, avg_valid, warm, black,
               node_pulse, node_count
    );

    modport slave (
        input  frame_valid, d_out_ch5, d_out_ch6, d_out_ch7,
        output avg_ch5, avg_ch6, avg_ch7, avg_valid, warm, black,
               node_pulse, node_count
    );
endinterface

// File: rtl/line_sensor_filter.sv
// Three-channel line-sensor filter: moving average, hysteresis black/white
// decision and all-black node detection for the navigation FSM.
module line_sensor_filter #(
    parameter int DATA_W      = 12,
    parameter int AVG_LOG2    = 2,
    parameter int TH_HIGH     = 1800,
    parameter int TH_LOW      = 1400,
    parameter int NODE_FRAMES = 3
) (
    input logic clk_50,
    input logic rst,
    line_sensor_filter_if.slave bus
);
    localparam int WIN    = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [DATA_W-1:0] TH_HI  = DATA_W'(TH_HIGH);
    localparam logic [DATA_W-1:0] TH_LO  = DATA_W'(TH_LOW);
    localparam logic [7:0]        NODE_N = 8'(NODE_FRAMES);

    typedef enum logic [1:0] {IDLE, RUN, LOCK} node_state_t;

    logic [DATA_W-1:0] sample [3];
    logic [DATA_W-1:0] win    [3][WIN];
    logic [SUM_W-1:0]  sum    [3];
    logic [DATA_W-1:0] avg    [3];
    logic [FILL_W-1:0] fill;
    logic              s1_valid;
    logic              update;
    logic [2:0]        black_next;
    logic              all_black;

    node_state_t state, state_next;
    logic [7:0]  run, run_next;
    logic        node_fire;

    assign sample[0] = bus.d_out_ch5;
    assign sample[1] = bus.d_out_ch6;
    assign sample[2] = bus.d_out_ch7;

    // Stage 1: the window starts zeroed, so subtracting the oldest entry is
    // also correct while the window is still filling.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            s1_valid <= 1'b0;
            fill     <= '0;
            for (int c = 0; c < 3; c++) begin
                sum[c] <= '0;
                for (int i = 0; i < WIN; i++) win[c][i] <= '0;
            end
        end else begin
            s1_valid <= bus.frame_valid;
            if (bus.frame_valid) begin
                if (fill != FILL_W'(WIN)) fill <= fill + FILL_W'(1);
                for (int c = 0; c < 3; c++) begin
                    sum[c]    <= sum[c] + SUM_W'(sample[c]) - SUM_W'(win[c][WIN-1]);
                    win[c][0] <= sample[c];
                    for (int i = WIN - 1; i > 0; i--) win[c][i] <= win[c][i-1];
                end
            end
        end
    end

    assign update = s1_valid && (fill == FILL_W'(WIN));

    always_comb begin
        for (int c = 0; c < 3; c++) avg[c] = DATA_W'(sum[c] >> AVG_LOG2);
    end

    // Channel 5 is the left sensor and lands in the MSB of black.
    always_comb begin
        black_next = bus.black;
        for (int c = 0; c < 3; c++) begin
            if (avg[c] >= TH_HI)      black_next[2-c] = 1'b1;
            else if (avg[c] <= TH_LO) black_next[2-c] = 1'b0;
        end
    end

    assign all_black = &black_next;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
            run   <= '0;
        end else if (update) begin
            state <= state_next;
            run   <= run_next;
        end
    end

    always_comb begin
        state_next = state;
        run_next   = run;
        case (state)
            IDLE: begin
                if (all_black) begin
                    run_next   = 8'd1;
                    state_next = (NODE_N <= 8'd1) ? LOCK : RUN;
                end
            end
            RUN: begin
                if (!all_black) begin
                    state_next = IDLE;
                    run_next   = '0;
                end else if (run + 8'd1 >= NODE_N) begin
                    state_next = LOCK;
                    run_next   = '0;
                end else begin
                    run_next = run + 8'd1;
                end
            end
            LOCK: begin
                if (!all_black) state_next = IDLE;
                run_next = '0;
            end
            default: begin
                state_next = IDLE;
                run_next   = '0;
            end
        endcase
    end

    // A node is declared exactly on the transition into LOCK.
    always_comb begin
        node_fire = update && (state != LOCK) && (state_next == LOCK);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            bus.avg_ch5    <= '0;
            bus.avg_ch6    <= '0;
            bus.avg_ch7    <= '0;
            bus.avg_valid  <= 1'b0;
            bus.warm       <= 1'b0;
            bus.black      <= '0;
            bus.node_pulse <= 1'b0;
            bus.node_count <= '0;
        end else begin
            bus.avg_valid  <= update;
            bus.node_pulse <= node_fire;
            if (update) begin
                bus.avg_ch5 <= avg[0];
                bus.avg_ch6 <= avg[1];
                bus.avg_ch7 <= avg[2];
                bus.warm    <= 1'b1;
                bus.black   <= black_next;
            end
            if (node_fire) bus.node_count <= bus.node_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_line_sensor_filter.sv
// Randomised and directed bench for line_sensor_filter, checked every cycle
// against a sample-history reference model.
module tb_line_sensor_filter;
    localparam int DATA_W      = 12;
    localparam int AVG_LOG2    = 2;
    localparam int WIN         = 4;
    localparam int TH_HIGH     = 1800;
    localparam int TH_LOW      = 1400;
    localparam int NODE_FRAMES = 3;

    logic clk_50 = 1'b0;
    logic rst;

    always #10 clk_50 = ~clk_50;

    line_sensor_filter_if #(.DATA_W(DATA_W)) bus ();

    line_sensor_filter #(
        .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .TH_HIGH(TH_HIGH),
        .TH_LOW(TH_LOW), .NODE_FRAMES(NODE_FRAMES)
    ) dut (
        .clk_50(clk_50),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        int          due;
        logic [11:0] a5;
        logic [11:0] a6;
        logic [11:0] a7;
        logic [2:0]  blk;
        logic        pulse;
        logic [7:0]  count;
    } exp_t;

    int   hist [3][$];
    int   frames;
    logic [2:0] m_black;
    int   streak;
    int   m_count;
    exp_t pending [$];

    logic [11:0] e_a5, e_a6, e_a7;
    logic        e_valid, e_warm, e_pulse;
    logic [2:0]  e_black;
    logic [7:0]  e_count;

    int cyc;
    int errors;
    int checks;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < 3; ch++) hist[ch].delete();
        pending.delete();
        frames  = 0;
        m_black = 3'b000;
        streak  = 0;
        m_count = 0;
        e_a5 = '0; e_a6 = '0; e_a7 = '0;
        e_valid = 1'b0; e_warm = 1'b0; e_pulse = 1'b0;
        e_black = '0; e_count = '0;
    endtask

    // Average of the last WIN samples; node when the all-black streak hits NODE_FRAMES.
    task automatic modelFrame(input int a, input int b, input int c);
        int   s [3];
        int   av [3];
        int   total;
        exp_t e;
        s[0] = a; s[1] = b; s[2] = c;
        for (int ch = 0; ch < 3; ch++) begin
            hist[ch].push_back(s[ch]);
            if (hist[ch].size() > WIN) void'(hist[ch].pop_front());
        end
        frames++;
        if (frames >= WIN) begin
            for (int ch = 0; ch < 3; ch++) begin
                total = 0;
                for (int i = 0; i < hist[ch].size(); i++) total += hist[ch][i];
                av[ch] = total / WIN;
                if (av[ch] >= TH_HIGH)     m_black[2-ch] = 1'b1;
                else if (av[ch] <= TH_LOW) m_black[2-ch] = 1'b0;
            end
            if (m_black == 3'b111) streak++;
            else streak = 0;
            e.pulse = (streak == NODE_FRAMES);
            if (e.pulse) m_count = (m_count + 1) % 256;
            e.due   = cyc + 2;
            e.a5    = 12'(av[0]);
            e.a6    = 12'(av[1]);
            e.a7    = 12'(av[2]);
            e.blk   = m_black;
            e.count = 8'(m_count);
            pending.push_back(e);
        end
    endtask

    task automatic checkAll();
        exp_t e;
        e_valid = 1'b0;
        e_pulse = 1'b0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            e = pending.pop_front();
            e_a5 = e.a5; e_a6 = e.a6; e_a7 = e.a7;
            e_black = e.blk; e_count = e.count;
            e_pulse = e.pulse;
            e_valid = 1'b1;
            e_warm  = 1'b1;
        end
        checkOutput("avg_valid",  bus.avg_valid,  e_valid);
        checkOutput("node_pulse", bus.node_pulse, e_pulse);
        checkOutput("avg_ch5",    bus.avg_ch5,    e_a5);
        checkOutput("avg_ch6",    bus.avg_ch6,    e_a6);
        checkOutput("avg_ch7",    bus.avg_ch7,    e_a7);
        checkOutput("warm",       bus.warm,       e_warm);
        checkOutput("black",      bus.black,      e_black);
        checkOutput("node_count", bus.node_count, e_count);
    endtask

    task automatic applyStimulus(input logic r, input logic fv, input int a, input int b, input int c);
        @(negedge clk_50);
        cyc++;
        checkAll();
        rst             = r;
        bus.frame_valid = fv;
        bus.d_out_ch5   = 12'(a);
        bus.d_out_ch6   = 12'(b);
        bus.d_out_ch7   = 12'(c);
        if (r) modelReset();
        else if (fv) modelFrame(a, b, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    endtask

    task automatic strobe(input int a, input int b, input int c);
        applyStimulus(1'b0, 1'b1, a, b, c);
        idle(2);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int mode;
        int v [3];
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst             = 1'b1;
        bus.frame_valid = 1'b0;
        bus.d_out_ch5   = '0;
        bus.d_out_ch6   = '0;
        bus.d_out_ch7   = '0;
        modelReset();
        @(posedge clk_50);
        doReset();

        // Warm-up, first node, lock, hold-through-1500 and rearm.
        for (int k = 1; k <= 10; k++) strobe(2000, 2000, 2000);
        checkOutput("node_count_locked", bus.node_count, 1);
        strobe(0, 0, 0);
        strobe(2000, 2000, 2000);
        strobe(2000, 2000, 2000);
        checkOutput("black_hold_1500", bus.black, 3'b111);
        strobe(0, 0, 0);
        for (int k = 0; k < 6; k++) strobe(2000, 2000, 2000);
        checkOutput("node_count_rearm", bus.node_count, 2);

        // Hysteresis on the left channel at the inclusive boundaries.
        for (int k = 0; k < 4; k++) strobe(1800, 3000, 3000);
        checkOutput("hyst_1800_set", bus.black[2], 1);
        for (int k = 0; k < 4; k++) strobe(1401, 3000, 3000);
        checkOutput("hyst_1401_hold", bus.black[2], 1);
        for (int k = 0; k < 4; k++) strobe(1400, 3000, 3000);
        checkOutput("hyst_1400_clear", bus.black[2], 0);
        for (int k = 0; k < 4; k++) strobe(1799, 3000, 3000);
        checkOutput("hyst_1799_hold", bus.black[2], 0);

        // Full-scale and truncation.
        doReset();
        for (int k = 0; k < 4; k++) strobe(4095, 4095, 4095);
        checkOutput("avg_full_scale", bus.avg_ch5, 4095);
        doReset();
        strobe(1, 1, 1);
        for (int k = 0; k < 3; k++) strobe(2, 2, 2);
        checkOutput("avg_truncate", bus.avg_ch6, 1);

        // Back-to-back strobes.
        doReset();
        for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 1'b1, k * 100, k * 100, k * 100);
        idle(3);
        checkOutput("b2b_last_avg", bus.avg_ch7, 450);

        // Reset one cycle after the fourth strobe.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 2000, 2000, 2000);
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        idle(3);
        checkOutput("warm_after_reset", bus.warm, 0);
        for (int k = 0; k < 4; k++) strobe(2000, 2000, 2000);
        checkOutput("warm_refill", bus.warm, 1);
        checkOutput("node_count_restart", bus.node_count, 0);

        // Random frames, gaps and rare resets.
        for (int k = 0; k < 600; k++) begin
            mode = int'($urandom_range(0, 3));
            for (int ch = 0; ch < 3; ch++) begin
                if (mode <= 1)      v[ch] = int'($urandom_range(1800, 4095));
                else if (mode == 2) v[ch] = int'($urandom_range(0, 4095));
                else                v[ch] = int'($urandom_range(1395, 1805));
            end
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, v[0], v[1], v[2]);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
